// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader writing a framed RX byte stream into instruction memory
// Frame: LEN_LO LEN_HI, 4*N little-endian payload bytes, XOR checksum; CPU held until done.
module imem_loader #(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  load_req,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int              GAP_W     = $clog2(TIMEOUT_CYCLES) + 1;
  // Leaving the cycle at this count with no byte means the counter reaches TIMEOUT_CYCLES-1.
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 2);
  localparam logic [32:0]     MAX_WORDS = 33'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [7:0]       len_lo;
  logic [15:0]      word_cnt;
  logic [1:0]       byte_idx;
  logic [23:0]      word_buf;
  logic [7:0]       csum;
  logic [GAP_W-1:0] gap;

  logic in_frame;
  logic accept;
  logic timeout;
  logic start;
  logic len_bad;
  logic word_end;
  logic last_word;
  logic csum_ok;

  assign in_frame  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CSUM);
  assign accept    = in_frame && rx_valid;
  assign timeout   = in_frame && !rx_valid && (gap == GAP_LAST);
  assign start     = load_req && ((state == S_IDLE) || (state == S_ERR));
  assign len_bad   = ({rx_data, len_lo} == 16'd0) ||
                     ({17'd0, rx_data, len_lo} > MAX_WORDS);
  assign word_end  = (state == S_DATA) && accept && (byte_idx == 2'd3);
  assign last_word = (32'(words_written) + 32'd1) == 32'(word_cnt);
  assign csum_ok   = (rx_data == csum);

  assign cpu_hold  = (state != S_IDLE);
  assign load_err  = (state == S_ERR);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept)       state_nx = S_LEN_HI;
        else if (timeout) state_nx = S_ERR;
      end
      S_LEN_HI: begin
        if (accept)       state_nx = len_bad ? S_ERR : S_DATA;
        else if (timeout) state_nx = S_ERR;
      end
      S_DATA: begin
        if (word_end && last_word) state_nx = S_CSUM;
        else if (timeout)          state_nx = S_ERR;
      end
      S_CSUM: begin
        if (accept)       state_nx = csum_ok ? S_IDLE : S_ERR;
        else if (timeout) state_nx = S_ERR;
      end
      S_ERR: begin
        if (start) state_nx = S_LEN_LO;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      load_done     <= 1'b0;
      words_written <= '0;
      len_lo        <= '0;
      word_cnt      <= '0;
      byte_idx      <= '0;
      word_buf      <= '0;
      csum          <= '0;
      gap           <= '0;
    end else begin
      imem_we   <= 1'b0;
      load_done <= (state == S_CSUM) && accept && csum_ok;
      if (start) begin
        words_written <= '0;
        csum          <= '0;
        byte_idx      <= '0;
        word_buf      <= '0;
        gap           <= '0;
      end else if (in_frame) begin
        if (accept)               gap <= '0;
        else if (gap != GAP_LAST) gap <= gap + 1'b1;

        if ((state == S_LEN_LO) && accept) len_lo   <= rx_data;
        if ((state == S_LEN_HI) && accept) word_cnt <= {rx_data, len_lo};

        if ((state == S_DATA) && accept) begin
          csum     <= csum ^ rx_data;
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0: word_buf[7:0]   <= rx_data;
            2'd1: word_buf[15:8]  <= rx_data;
            2'd2: word_buf[23:16] <= rx_data;
            default: begin
              // Word index and words_written are the same count; it never exceeds N-1 here.
              imem_we       <= 1'b1;
              imem_addr     <= words_written[ADDR_WIDTH-1:0];
              imem_wdata    <= {rx_data, word_buf};
              words_written <= words_written + 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized frame-level checking of imem_loader against a reference model
module tb_imem_loader;

  localparam int AW = 4;
  localparam int TO = 16;

  logic          sys_clk  = 1'b0;
  logic          rst_n    = 1'b0;
  logic          load_req = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data  = 8'd0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_written;

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .load_req      (load_req),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_err      (load_err),
    .words_written (words_written)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]    frame[$];
  int            gaps[$];
  logic [31:0]   exp_data[$];
  int            exp_done;
  bit            exp_err;
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  int            done_cnt = 0;

  always @(negedge sys_clk) begin
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
    if (load_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " imem_we"}, 64'(imem_we), 64'(0));
    chk({tag, " imem_addr"}, 64'(imem_addr), 64'(0));
    chk({tag, " imem_wdata"}, 64'(imem_wdata), 64'(0));
    chk({tag, " cpu_hold"}, 64'(cpu_hold), 64'(0));
    chk({tag, " load_done"}, 64'(load_done), 64'(0));
    chk({tag, " load_err"}, 64'(load_err), 64'(0));
    chk({tag, " words_written"}, 64'(words_written), 64'(0));
  endtask

  task automatic start_load();
    load_req = 1'b1;
    @(negedge sys_clk);
    load_req = 1'b0;
  endtask

  task automatic build(input int n, input logic [7:0] flip);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'd0;
    frame.delete();
    gaps.delete();
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      cs ^= b;
      frame.push_back(b);
    end
    frame.push_back(cs ^ flip);
    for (int i = 0; i < frame.size(); i++) gaps.push_back(int'($urandom_range(3, 0)));
  endtask

  task automatic send_range(input int lo, input int hi, input int mid_req);
    for (int i = lo; i <= hi; i++) begin
      repeat (gaps[i]) @(negedge sys_clk);
      rx_data  = frame[i];
      rx_valid = 1'b1;
      load_req = (i == mid_req);
      @(negedge sys_clk);
      rx_valid = 1'b0;
      load_req = 1'b0;
    end
  endtask

  // Frame-level reference: walk the bytes by position, applying header, payload,
  // checksum and inter-byte gap rules to predict words, done and error.
  task automatic model(input int upto);
    int n;
    int idx;
    logic [31:0] w;
    logic [7:0]  cs;
    exp_data.delete();
    exp_done = 0;
    exp_err  = 1'b0;
    n  = 0;
    cs = 8'd0;
    w  = 32'd0;
    for (int i = 0; i < upto; i++) begin
      if (gaps[i] >= TO - 1) begin
        exp_err = 1'b1;
        break;
      end
      if (i == 0) begin
        n = int'(frame[0]);
      end else if (i == 1) begin
        n += 256 * int'(frame[1]);
        if (n == 0 || n > (1 << AW)) begin
          exp_err = 1'b1;
          break;
        end
      end else if (i < 2 + 4 * n) begin
        idx = (i - 2) % 4;
        cs ^= frame[i];
        w[8*idx +: 8] = frame[i];
        if (idx == 3) exp_data.push_back(w);
      end else begin
        if (frame[i] == cs) exp_done = 1;
        else exp_err = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int bw, input int bd);
    repeat (3) @(negedge sys_clk);
    chk({tag, " nwords"}, 64'(got_data.size() - bw), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size(); i++) begin
      if (bw + i < got_data.size()) begin
        chk({tag, " addr"}, 64'(got_addr[bw+i]), 64'(i));
        chk({tag, " data"}, 64'(got_data[bw+i]), 64'(exp_data[i]));
      end
    end
    chk({tag, " done_pulses"}, 64'(done_cnt - bd), 64'(exp_done));
    chk({tag, " load_err"}, 64'(load_err), 64'(exp_err));
    chk({tag, " cpu_hold"}, 64'(cpu_hold), 64'(exp_err));
    chk({tag, " words_written"}, 64'(words_written), 64'(exp_data.size()));
  endtask

  task automatic run_frame(input string tag, input int mid_req);
    int bw;
    int bd;
    bw = got_data.size();
    bd = done_cnt;
    start_load();
    chk({tag, " hold_on_start"}, 64'(cpu_hold), 64'(1));
    chk({tag, " err_clear_on_start"}, 64'(load_err), 64'(0));
    send_range(0, frame.size() - 1, mid_req);
    model(frame.size());
    check_frame(tag, bw, bd);
  endtask

  task automatic idle_bytes(input int count);
    for (int i = 0; i < count; i++) begin
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
      @(negedge sys_clk);
      rx_valid = 1'b0;
    end
  endtask

  initial begin
    int bw;
    int bd;
    int k;

    repeat (2) @(negedge sys_clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge sys_clk);

    // Documented two-word frame, checksum correct
    build(2, 8'h00);
    frame[2] = 8'h78; frame[3] = 8'h56; frame[4]  = 8'h34; frame[5] = 8'h12;
    frame[6] = 8'hEF; frame[7] = 8'hBE; frame[8]  = 8'hAD; frame[9] = 8'hDE;
    frame[10] = 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE;
    foreach (gaps[i]) gaps[i] = 0;
    bw = got_data.size();
    bd = done_cnt;
    start_load();
    send_range(0, 9, -1);
    send_range(10, 10, -1);
    chk("two_word done_pulse", 64'(load_done), 64'(1));
    chk("two_word hold_fall", 64'(cpu_hold), 64'(0));
    model(frame.size());
    check_frame("two_word", bw, bd);
    if (got_data.size() >= bw + 2) begin
      chk("two_word word0", 64'(got_data[bw]), 64'(32'h12345678));
      chk("two_word word1", 64'(got_data[bw+1]), 64'(32'hDEADBEEF));
    end

    // Same frame, corrupted checksum
    frame[10] = frame[10] ^ 8'h01;
    run_frame("bad_csum", -1);

    bw = got_data.size();
    idle_bytes(5);
    chk("err_ignore load_err", 64'(load_err), 64'(1));
    chk("err_ignore words", 64'(words_written), 64'(2));
    chk("err_ignore no_we", 64'(got_data.size() - bw), 64'(0));

    build(1, 8'h00);
    run_frame("recover", -1);

    bw = got_data.size();
    bd = done_cnt;
    idle_bytes(6);
    chk("idle_ignore hold", 64'(cpu_hold), 64'(0));
    chk("idle_ignore words", 64'(words_written), 64'(1));
    chk("idle_ignore no_we", 64'(got_data.size() - bw), 64'(0));
    chk("idle_ignore no_done", 64'(done_cnt - bd), 64'(0));

    // Zero-length header errors right after LEN_HI
    frame.delete(); gaps.delete();
    frame.push_back(8'h00); frame.push_back(8'h00);
    gaps.push_back(0); gaps.push_back(0);
    bw = got_data.size();
    bd = done_cnt;
    start_load();
    send_range(0, 1, -1);
    chk("len_zero err_immediate", 64'(load_err), 64'(1));
    model(frame.size());
    check_frame("len_zero", bw, bd);

    build((1 << AW) + 1, 8'h00);
    run_frame("len_over", -1);
    build(1 << AW, 8'h00);
    run_frame("len_max", -1);

    // Timeout: header plus three payload bytes, then silence
    build(2, 8'h00);
    foreach (gaps[i]) gaps[i] = 0;
    start_load();
    send_range(0, 4, -1);
    k = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge sys_clk);
      if (load_err && k == 0) k = j;
    end
    chk("timeout cycle", 64'(k), 64'(15));
    chk("timeout words", 64'(words_written), 64'(0));

    build(2, 8'h00);
    foreach (gaps[i]) gaps[i] = 0;
    gaps[5] = TO - 2;
    run_frame("gap_last_ok", -1);

    build(2, 8'h00);
    foreach (gaps[i]) gaps[i] = 0;
    gaps[3] = TO - 1;
    run_frame("gap_timeout", -1);

    // Asynchronous reset mid-frame, after one complete word
    build(4, 8'h00);
    bw = got_data.size();
    start_load();
    send_range(0, 6, -1);
    model(7);
    repeat (2) @(negedge sys_clk);
    chk("pre_reset nwords", 64'(got_data.size() - bw), 64'(exp_data.size()));
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
    build(4, 8'h00);
    run_frame("post_reset", -1);

    build(3, 8'h00);
    run_frame("mid_data_req", 5);

    for (int it = 0; it < 6; it++) begin
      build(int'($urandom_range(4, 1)), 8'($urandom_range(1, 0)));
      run_frame("random", int'($urandom_range(12, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the fetch stage reads through its word-addressed port.
- Receives a framed byte stream from the serial RX block and assembles little-endian 32-bit words.
- Writes each word to consecutive instruction-memory addresses.
- Holds the CPU stalled for the whole load and reports completion or error.

Parameters:
- ADDR_WIDTH, 14, word-address width of the instruction memory (word address = pc[15:2]).
- TIMEOUT_CYCLES, 1000000, maximum sys_clk cycles allowed between accepted bytes inside a frame.

Ports:
- sys_clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- load_req  input  1  single-cycle pulse that starts a load.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
- rx_data  input  8  received byte.
- imem_we  output  1  instruction memory write enable, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_hold  output  1  high while loading or in error; drives the fetch stall.
- load_done  output  1  one-cycle pulse on successful completion.
- load_err  output  1  sticky error flag.
- words_written  output  ADDR_WIDTH+1  count of words written in the current or last load.

Behaviour:
- Frame format, in order:
  - LEN_LO, LEN_HI: word count N, 16 bits, little-endian.
  - 4*N payload bytes: byte k of each word goes to bits [8k+7:8k].
  - CSUM: one byte, the XOR of all payload bytes. Header bytes are excluded.
- Reset (rst_n low, async): state IDLE; all outputs and internal registers 0.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, ERR.
- IDLE:
  - rx_valid is ignored.
  - load_req goes to LEN_LO and sets cpu_hold=1 the following cycle.
  - Also clears words_written, the checksum accumulator, the byte index and the address.
- LEN_LO: an accepted byte stores N[7:0] and goes to LEN_HI.
- LEN_HI: an accepted byte stores N[15:8], then:
  - N==0 or N>2**ADDR_WIDTH: go to ERR.
  - Otherwise go to DATA.
- DATA:
  - Each accepted byte is XORed into the checksum and placed in the word buffer at the current byte index (0..3).
  - On the 4th byte, the next cycle presents imem_we=1 for exactly one cycle, with imem_addr = current word index and imem_wdata = assembled word.
  - The word index and words_written then increment; the byte index wraps to 0.
  - When words_written reaches N, go to CSUM. No payload byte is consumed after the Nth word.
- CSUM:
  - Accepted byte equals the accumulator: go to IDLE, pulse load_done for one cycle, cpu_hold=0 from the same cycle.
  - Mismatch: go to ERR.
- ERR:
  - load_err=1 and cpu_hold=1, both held.
  - rx_valid is ignored.
  - load_req clears load_err and restarts exactly as from IDLE.
- Timeout:
  - The gap counter runs in LEN_LO..CSUM and resets to 0 on every accepted byte and on frame start.
  - Reaching TIMEOUT_CYCLES-1 goes to ERR.
  - If rx_valid arrives in the same cycle the counter reaches that value, the byte is accepted and there is no timeout.
- load_req while in LEN_LO..CSUM is ignored.
- imem_addr and imem_wdata hold their last values when imem_we=0. Addresses never exceed N-1; there is no wrap.
- Async reset mid-frame: all state discarded, cpu_hold drops. Memory contents already written are untouched.
- words_written holds its final value after DONE or ERR until the next load_req.

Test Plan:
- Reset, then load_req, then bytes 02 00 | 78 56 34 12 | EF BE AD DE | CSUM = XOR of the 8 payload bytes:
  - two imem_we pulses: addr 0 data 0x12345678, addr 1 data 0xDEADBEEF.
  - load_done pulses once; cpu_hold falls; words_written=2.
- Same frame with CSUM XOR 0x01 -> both words written, load_err=1, cpu_hold stays 1, no load_done. Then load_req -> load_err clears, and a correct 1-word frame completes.
- Header 00 00 -> ERR immediately after LEN_HI, no imem_we. Header with N = 2**ADDR_WIDTH+1 -> ERR.
- TIMEOUT_CYCLES=16, send 3 payload bytes then idle:
  - ERR asserted exactly 15 cycles after the last byte.
  - Repeat with a byte arriving at cycle 15 -> no error.
- Assert rst_n low after 5 payload bytes of a 4-word frame -> all outputs 0 asynchronously. A subsequent full frame loads correctly from addr 0.
- Bytes with rx_valid while in IDLE and ERR, and load_req pulsed mid-DATA -> no effect on state, counters or imem_we.
